// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers for vga_timing and its axis counters.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CLK_DIV   = 2;

  function automatic int axis_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered visible/sync decode taken from the
// next-state count, so the decoded flags change on the same edge as the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               active,
  output logic               sync_n
);

  localparam logic [COORD_W-1:0] LAST   = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] VIS    = COORD_W'(VISIBLE);
  localparam logic [COORD_W-1:0] SYNC_S = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SYNC_E = COORD_W'(SYNC_END);

  logic [COORD_W-1:0] count_reg;
  logic [COORD_W-1:0] count_next;
  logic               active_reg;
  logic               sync_n_reg;

  always_comb begin
    wrap       = en && (count_reg == LAST);
    count_next = count_reg;
    if (en) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + COORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= LAST;
      active_reg <= 1'b0;
      sync_n_reg <= 1'b1;
    end else begin
      count_reg  <= count_next;
      active_reg <= (count_next < VIS);
      sync_n_reg <= !((count_next >= SYNC_S) && (count_next < SYNC_E));
    end
  end

  assign count  = count_reg;
  assign active = active_reg;
  assign sync_n = sync_n_reg;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator feeding bitgen. Define VGA_CLKDIV_EN to build the internal
// clk/CLK_DIV pixel divider; otherwise clk is the pixel clock and every edge is a pixel tick.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               hsync,
  output logic               vsync,
  output logic               bright,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic               frame_start
);

  localparam int H_TOT = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
      $fatal(1, "vga_timing: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
      $fatal(1, "vga_timing: CLK_DIV must be at least 1");
    end
  endgenerate

  logic pix_tick;
  logic h_wrap;
  logic v_wrap;
  logic h_active;
  logic v_active;
  logic frame_start_reg;

`ifdef VGA_CLKDIV_EN
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;

  assign pix_tick = (div_reg == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= '0;
    end else begin
      div_reg <= pix_tick ? '0 : div_reg + DIV_W'(1);
    end
  end
`else
  assign pix_tick = 1'b1;
`endif

  vga_axis_counter #(
    .TOTAL     (H_TOT),
    .VISIBLE   (H_VISIBLE),
    .SYNC_START(H_VISIBLE + H_FP),
    .SYNC_END  (H_VISIBLE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (pix_tick),
    .count  (hcount),
    .wrap   (h_wrap),
    .active (h_active),
    .sync_n (hsync)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOT),
    .VISIBLE   (V_VISIBLE),
    .SYNC_START(V_VISIBLE + V_FP),
    .SYNC_END  (V_VISIBLE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (pix_tick & h_wrap),
    .count  (vcount),
    .wrap   (v_wrap),
    .active (v_active),
    .sync_n (vsync)
  );

  // v_wrap already implies pix_tick & h_wrap: this is the tick that lands on (0,0)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= v_wrap;
    end
  end

  assign bright      = h_active & v_active;
  assign frame_start = frame_start_reg;

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates VGA 640x480@60 raster timing for the display path.
- Produces the per-pixel hcount/vcount/bright that the pixel colour generator (bitgen) consumes directly, plus active-low hsync/vsync for the connector.
- Sits between the board clock and bitgen.
- Video coordinates: hcount/vcount equal the visible pixel coordinate whenever bright=1.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel when divider compiled in (50 MHz -> 25 MHz)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- bright  out  1  1 while (hcount,vcount) is inside the visible area
- hcount  out  10  horizontal pixel counter, 0..H_TOTAL-1
- vcount  out  10  vertical line counter, 0..V_TOTAL-1
- frame_start  out  1  one-clk pulse on the tick entering (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL=V_VISIBLE+V_FP+V_SYNC+V_BP (525)
  - Both must be <=1024; checked by elaboration-time assertion.
- Counter order per axis: visible, front porch, sync, back porch.
- Clock/reset: one clock (clk); reset_n is asynchronous, active low. All state clears immediately on reset_n=0, regardless of clock.
- Reset values:
  - hcount=H_TOTAL-1 (799), vcount=V_TOTAL-1 (524)
  - hsync=1, vsync=1, bright=0, frame_start=0
  - divider count=0
  - Net effect: the first pixel tick after reset lands on (0,0).
- Pixel tick pix_tick:
  - Asserted on the clk cycle where divider count==CLK_DIV-1; the count then wraps to 0.
  - First tick occurs CLK_DIV clk edges after reset release.
- On pix_tick:
  - If hcount==H_TOTAL-1: hcount<=0, and vcount<=(vcount==V_TOTAL-1) ? 0 : vcount+1.
  - Otherwise hcount<=hcount+1, vcount unchanged.
- No tick: all counters and outputs hold.
- Output decoding:
  - hsync, vsync and bright are registered, decoded from the next-state counter values and updated on the same edge as the counters, so all outputs are mutually aligned with zero skew.
  - hsync=0 iff H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vsync=0 iff V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC (490..491).
  - bright=1 iff h<H_VISIBLE and v<V_VISIBLE.
- frame_start: 1 for exactly the clk cycle in which (hcount,vcount) becomes (0,0), including the first tick after reset; 0 otherwise.
- Wrap-around: simultaneous h and v wrap at (799,524)->(0,0) within a single tick; no intermediate state visible.
- Reset mid-frame: outputs return to reset values asynchronously; timing restarts from (799,524).
- Latency: counter-to-output latency is 0; outputs are valid from the edge that changes the counters.

Optional Feature:
- Macro: VGA_CLKDIV_EN.
- Defined: internal divider per CLK_DIV; pix_tick every CLK_DIV clk cycles.
- Undefined: divider removed; pix_tick is constant 1; one pixel per clk (clk must be the 25 MHz pixel clock); CLK_DIV is ignored.

Decomposition:
- Package vga_pkg:
  - The eight default timing constants, plus derived H_TOTAL and V_TOTAL as functions of the parameters.
  - Coordinate width constant COORD_W=10.
- One sub-module: vga_axis_counter.
  - Parameters: TOTAL, VISIBLE, SYNC_START, SYNC_END.
  - Inputs: clk, reset_n, en.
  - Outputs: count, wrap, active, sync_n.
  - Instantiated twice: horizontal with en=pix_tick; vertical with en=pix_tick & h_wrap.

Test Plan:
- Reset release, divider in:
  - During reset: hcount=799, vcount=524, hsync=1, vsync=1, bright=0, frame_start=0.
  - 2nd clk edge after release: (0,0), bright=1, frame_start=1 for exactly 1 clk.
- Line 0: bright high for 640 ticks (1280 clk); falls on the edge hcount becomes 640; hcount reaches 799 then wraps to 0 with vcount=1.
- hsync: low for hcount 656..751 (96 ticks, 192 clk) on every line, including blanked lines.
- Frame:
  - vsync low throughout vcount 490..491 (1600 ticks).
  - bright=0 for all vcount>=480.
  - frame_start period exactly 840000 clk.
- Asynchronous reset_n pulse mid-frame at (300,200), between clk edges: outputs take reset values immediately; after release, first tick gives (0,0) and frame_start.
- VGA_CLKDIV_EN undefined: counters advance every clk; frame_start period 420000 clk; hsync low 96 consecutive clk per line.
